// File: rtl/lc3_pkg.sv
// LC-3 memory stage shared types: device addresses, access FSM state,
// timeout sizing and the decoded I/O register select bundle.
package lc3_pkg;

  localparam logic [15:0] KBSR_A = 16'hFE00;
  localparam logic [15:0] KBDR_A = 16'hFE02;
  localparam logic [15:0] DSR_A  = 16'hFE04;
  localparam logic [15:0] DDR_A  = 16'hFE06;

  localparam int MEM_TO   = 64;
  localparam int MEM_TO_W = $clog2(MEM_TO + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    DONE     = 2'd2
  } mio_state_t;

  typedef struct packed {
    logic kbsr;
    logic kbdr;
    logic dsr;
    logic ddr;
  } io_sel_t;

  function automatic logic any_io(input io_sel_t s);
    return s.kbsr | s.kbdr | s.dsr | s.ddr;
  endfunction

endpackage

// File: rtl/mem_io_interface_kbd_dsp_regs.sv
// Keyboard/display registers: KBSR, KBDR, DSR and the DDR output port.
// Ports: clk/rst_n, decoded sel + rd_en/wr_en strobes, kb/dd side, rdata mux.
module kbd_dsp_regs
  import lc3_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  io_sel_t     sel,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [7:0]  wdata,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  input  logic        dd_done,
  output logic [15:0] rdata,
  output logic        dd_valid,
  output logic [7:0]  dd_data
);

  logic       kb_rdy;
  logic       kb_ovr;
  logic [7:0] kbdr;
  logic       ds_rdy;
  logic       ddr_acc;

  assign ddr_acc = wr_en & sel.ddr & ds_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kb_rdy   <= 1'b0;
      kb_ovr   <= 1'b0;
      kbdr     <= 8'h00;
      ds_rdy   <= 1'b1;
      dd_valid <= 1'b0;
      dd_data  <= 8'h00;
    end else begin
      // a new char beats a same-edge clearing read
      if (kb_valid) begin
        kbdr   <= kb_data;
        kb_rdy <= 1'b1;
      end else if (rd_en && sel.kbdr) begin
        kb_rdy <= 1'b0;
      end
      if (kb_valid && kb_rdy) begin
        kb_ovr <= 1'b1;
      end else if (rd_en && sel.kbsr) begin
        kb_ovr <= 1'b0;
      end
      // an accepted DDR write beats a same-edge dd_done
      if (ddr_acc) begin
        ds_rdy  <= 1'b0;
        dd_data <= wdata;
      end else if (dd_done) begin
        ds_rdy <= 1'b1;
      end
      dd_valid <= ddr_acc;
    end
  end

  always_comb begin
    rdata = 16'h0000;
    unique case (1'b1)
      sel.kbsr: rdata = {kb_rdy, kb_ovr, 14'h0};
      sel.kbdr: rdata = {8'h00, kbdr};
      sel.dsr:  rdata = {ds_rdy, 15'h0};
      default:  rdata = 16'h0000;
    endcase
  end

endmodule

// File: rtl/mem_io_interface.sv
// LC-3 memory stage: MAR/MDR, I/O decode, req/ack external memory access.
// Ports: control (LD_MAR/LD_MDR/MIO_EN/RW), bus, o_R, memory, kbd, display.
module mem_io_interface
  import lc3_pkg::*;
#(
  parameter int          MEM_TIMEOUT = MEM_TO,
  parameter logic [15:0] KBSR_ADDR   = KBSR_A,
  parameter logic [15:0] KBDR_ADDR   = KBDR_A,
  parameter logic [15:0] DSR_ADDR    = DSR_A,
  parameter logic [15:0] DDR_ADDR    = DDR_A
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic [15:0] i_bus,
  input  logic        LD_MAR,
  input  logic        LD_MDR,
  input  logic        MIO_EN,
  input  logic        RW,
  output logic [15:0] o_MAR,
  output logic [15:0] o_MDR,
  output logic        o_R,
  output logic        o_bus_err,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [15:0] o_mem_addr,
  output logic [15:0] o_mem_wdata,
  input  logic [15:0] i_mem_rdata,
  input  logic        i_mem_ack,
  input  logic        i_kb_valid,
  input  logic [7:0]  i_kb_data,
  output logic        o_dd_valid,
  output logic [7:0]  o_dd_data,
  input  logic        i_dd_done
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] LAST = TW'(MEM_TIMEOUT - 1);

  mio_state_t    state;
  logic [15:0]   mar;
  logic [15:0]   mdr;
  logic          we;
  logic          err;
  logic [TW-1:0] cnt;

  io_sel_t       sel;
  logic          io_hit;
  logic          io_go;
  logic [15:0]   io_rdata;

  always_comb begin
    sel.kbsr = (mar == KBSR_ADDR);
    sel.kbdr = (mar == KBDR_ADDR);
    sel.dsr  = (mar == DSR_ADDR);
    sel.ddr  = (mar == DDR_ADDR);
  end

  assign io_hit = any_io(sel);
  assign io_go  = (state == IDLE) & MIO_EN & io_hit;

  kbd_dsp_regs u_regs (
    .clk      (i_Clk),
    .rst_n    (i_Rst_n),
    .sel      (sel),
    .rd_en    (io_go & ~RW),
    .wr_en    (io_go & RW),
    .wdata    (mdr[7:0]),
    .kb_valid (i_kb_valid),
    .kb_data  (i_kb_data),
    .dd_done  (i_dd_done),
    .rdata    (io_rdata),
    .dd_valid (o_dd_valid),
    .dd_data  (o_dd_data)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state <= IDLE;
      mar   <= 16'h0000;
      mdr   <= 16'h0000;
      we    <= 1'b0;
      err   <= 1'b0;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (MIO_EN) begin
            if (io_hit) begin
              state <= DONE;
            end else begin
              state <= MEM_WAIT;
              we    <= RW;
              cnt   <= '0;
            end
          end
        end
        MEM_WAIT: begin
          if (i_mem_ack) begin
            state <= DONE;
            we    <= 1'b0;
          end else if (cnt == LAST) begin
            state <= DONE;
            we    <= 1'b0;
            err   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // address and write data are frozen while memory owns them
      if (LD_MAR && state != MEM_WAIT) begin
        mar <= i_bus;
      end

      if (state == MEM_WAIT && i_mem_ack && !we) begin
        mdr <= i_mem_rdata;
      end else if (io_go && !RW) begin
        mdr <= io_rdata;
      end else if (LD_MDR && !MIO_EN && state != MEM_WAIT) begin
        mdr <= i_bus;
      end
    end
  end

  assign o_MAR       = mar;
  assign o_MDR       = mdr;
  assign o_R         = (state == DONE);
  assign o_bus_err   = err;
  assign o_mem_req   = (state == MEM_WAIT);
  assign o_mem_we    = we;
  assign o_mem_addr  = mar;
  assign o_mem_wdata = mdr;

endmodule

// File: tb/tb_mem_io_interface.sv
// Directed bench for mem_io_interface: memory read/write, keyboard,
// display, timeout and reset-during-access scenarios.
module tb_mem_io_interface;

  logic        i_Clk = 1'b0;
  logic        i_Rst_n;
  logic [15:0] i_bus;
  logic        LD_MAR, LD_MDR, MIO_EN, RW;
  logic [15:0] o_MAR, o_MDR;
  logic        o_R, o_bus_err, o_mem_req, o_mem_we;
  logic [15:0] o_mem_addr, o_mem_wdata;
  logic [15:0] i_mem_rdata;
  logic        i_mem_ack;
  logic        i_kb_valid;
  logic [7:0]  i_kb_data;
  logic        o_dd_valid;
  logic [7:0]  o_dd_data;
  logic        i_dd_done;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 i_Clk = ~i_Clk;

  mem_io_interface dut (
    .i_Clk       (i_Clk),
    .i_Rst_n     (i_Rst_n),
    .i_bus       (i_bus),
    .LD_MAR      (LD_MAR),
    .LD_MDR      (LD_MDR),
    .MIO_EN      (MIO_EN),
    .RW          (RW),
    .o_MAR       (o_MAR),
    .o_MDR       (o_MDR),
    .o_R         (o_R),
    .o_bus_err   (o_bus_err),
    .o_mem_req   (o_mem_req),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_rdata (i_mem_rdata),
    .i_mem_ack   (i_mem_ack),
    .i_kb_valid  (i_kb_valid),
    .i_kb_data   (i_kb_data),
    .o_dd_valid  (o_dd_valid),
    .o_dd_data   (o_dd_data),
    .i_dd_done   (i_dd_done)
  );

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic set_mar(input logic [15:0] v);
    i_bus = v; LD_MAR = 1'b1; tick(); LD_MAR = 1'b0;
  endtask

  task automatic set_mdr(input logic [15:0] v);
    i_bus = v; LD_MDR = 1'b1; tick(); LD_MDR = 1'b0;
  endtask

  // single-cycle I/O access: returns at the DONE cycle, MIO_EN dropped
  task automatic io_start(input logic [15:0] a, input logic w);
    set_mar(a); RW = w; MIO_EN = 1'b1; tick(); MIO_EN = 1'b0;
  endtask

  task automatic test_reset();
    i_Rst_n = 1'b0;
    i_bus = 0; LD_MAR = 0; LD_MDR = 0; MIO_EN = 0; RW = 0;
    i_mem_rdata = 0; i_mem_ack = 0; i_kb_valid = 0; i_kb_data = 0;
    i_dd_done = 0;
    tick(); tick();
    n_chk++; if ({o_MAR, o_MDR} !== 32'h0) begin n_fail++;
      $display("FAIL reset_mar_mdr got %h/%h want 0/0", o_MAR, o_MDR); end
    n_chk++; if ({o_R, o_bus_err, o_mem_req, o_mem_we, o_dd_valid} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags got %b want 00000",
      {o_R, o_bus_err, o_mem_req, o_mem_we, o_dd_valid}); end
    n_chk++; if (o_dd_data !== 8'h00) begin n_fail++;
      $display("FAIL reset_dd_data got %h want 00", o_dd_data); end
    i_Rst_n = 1'b1;
    tick();
    io_start(16'hFE04, 1'b0);
    n_chk++; if (o_MDR !== 16'h8000) begin n_fail++;
      $display("FAIL reset_dsr got %h want 8000", o_MDR); end
    tick();
    io_start(16'hFE00, 1'b0);
    n_chk++; if (o_MDR !== 16'h0000) begin n_fail++;
      $display("FAIL reset_kbsr got %h want 0000", o_MDR); end
    tick();
  endtask

  task automatic test_mem_read();
    int reqs;
    reqs = 0;
    set_mar(16'h3000);
    n_chk++; if (o_MAR !== 16'h3000) begin n_fail++;
      $display("FAIL rd_mar got %h want 3000", o_MAR); end
    RW = 0; MIO_EN = 1; tick();
    for (int i = 0; i < 3; i++) begin
      if (o_mem_req === 1'b1 && o_R === 1'b0) reqs++;
      if (i == 2) begin i_mem_ack = 1; i_mem_rdata = 16'h1234; end
      tick();
    end
    i_mem_ack = 0; i_mem_rdata = 0;
    n_chk++; if (reqs !== 3) begin n_fail++;
      $display("FAIL rd_req_cycles got %0d want 3", reqs); end
    n_chk++; if ({o_R, o_mem_req} !== 2'b10) begin n_fail++;
      $display("FAIL rd_done got R=%b req=%b want 1/0", o_R, o_mem_req); end
    n_chk++; if (o_MDR !== 16'h1234) begin n_fail++;
      $display("FAIL rd_mdr got %h want 1234", o_MDR); end
    MIO_EN = 0; tick();
    n_chk++; if (o_R !== 1'b0) begin n_fail++;
      $display("FAIL rd_r_pulse got %b want 0", o_R); end
  endtask

  task automatic test_mem_write();
    set_mdr(16'hBEEF);
    set_mar(16'h4000);
    RW = 1; MIO_EN = 1; tick();
    n_chk++; if ({o_mem_req, o_mem_we} !== 2'b11) begin n_fail++;
      $display("FAIL wr_req_we got %b want 11", {o_mem_req, o_mem_we}); end
    n_chk++; if (o_mem_wdata !== 16'hBEEF) begin n_fail++;
      $display("FAIL wr_wdata got %h want BEEF", o_mem_wdata); end
    i_bus = 16'h5555; LD_MAR = 1; LD_MDR = 1; i_mem_ack = 1;
    tick();
    LD_MAR = 0; LD_MDR = 0; i_mem_ack = 0;
    n_chk++; if (o_R !== 1'b1) begin n_fail++;
      $display("FAIL wr_done got %b want 1", o_R); end
    n_chk++; if ({o_mem_addr, o_MDR} !== {16'h4000, 16'hBEEF}) begin n_fail++;
      $display("FAIL wr_hold got %h/%h want 4000/BEEF", o_mem_addr, o_MDR); end
    MIO_EN = 0; RW = 0; tick();
  endtask

  task automatic test_keyboard();
    i_kb_valid = 1; i_kb_data = 8'h41; tick(); i_kb_valid = 0;
    io_start(16'hFE00, 1'b0);
    n_chk++; if ({o_R, o_mem_req} !== 2'b10) begin n_fail++;
      $display("FAIL kb_io_latency got R=%b req=%b want 1/0", o_R, o_mem_req); end
    n_chk++; if (o_MDR !== 16'h8000) begin n_fail++;
      $display("FAIL kb_kbsr1 got %h want 8000", o_MDR); end
    tick();
    io_start(16'hFE02, 1'b0);
    n_chk++; if (o_MDR !== 16'h0041) begin n_fail++;
      $display("FAIL kb_kbdr got %h want 0041", o_MDR); end
    tick();
    io_start(16'hFE00, 1'b0);
    n_chk++; if (o_MDR !== 16'h0000) begin n_fail++;
      $display("FAIL kb_kbsr2 got %h want 0000", o_MDR); end
    tick();
    i_kb_valid = 1; i_kb_data = 8'h61; tick();
    i_kb_data = 8'h62; tick(); i_kb_valid = 0;
    io_start(16'hFE00, 1'b0);
    n_chk++; if (o_MDR !== 16'hC000) begin n_fail++;
      $display("FAIL kb_overrun got %h want C000", o_MDR); end
    tick();
    // KBDR read on the same edge as a new char: the set wins
    set_mar(16'hFE02); RW = 0; MIO_EN = 1;
    i_kb_valid = 1; i_kb_data = 8'h63; tick();
    i_kb_valid = 0; MIO_EN = 0;
    n_chk++; if (o_MDR !== 16'h0062) begin n_fail++;
      $display("FAIL kb_race_data got %h want 0062", o_MDR); end
    tick();
    io_start(16'hFE00, 1'b0);
    n_chk++; if (o_MDR !== 16'hC000) begin n_fail++;
      $display("FAIL kb_race_kbsr got %h want C000", o_MDR); end
    tick();
  endtask

  task automatic test_display();
    set_mdr(16'h0048);
    io_start(16'hFE06, 1'b1);
    n_chk++; if ({o_R, o_dd_valid, o_dd_data} !== {2'b11, 8'h48}) begin n_fail++;
      $display("FAIL dd_write got R=%b v=%b d=%h want 1/1/48",
      o_R, o_dd_valid, o_dd_data); end
    tick();
    n_chk++; if (o_dd_valid !== 1'b0) begin n_fail++;
      $display("FAIL dd_pulse got %b want 0", o_dd_valid); end
    io_start(16'hFE04, 1'b0);
    n_chk++; if (o_MDR !== 16'h0000) begin n_fail++;
      $display("FAIL dd_dsr_busy got %h want 0000", o_MDR); end
    tick();
    set_mdr(16'h0049);
    io_start(16'hFE06, 1'b1);
    n_chk++; if ({o_R, o_dd_valid, o_dd_data} !== {2'b10, 8'h48}) begin n_fail++;
      $display("FAIL dd_drop got R=%b v=%b d=%h want 1/0/48",
      o_R, o_dd_valid, o_dd_data); end
    tick();
    i_dd_done = 1; tick(); i_dd_done = 0;
    io_start(16'hFE04, 1'b0);
    n_chk++; if (o_MDR !== 16'h8000) begin n_fail++;
      $display("FAIL dd_dsr_ready got %h want 8000", o_MDR); end
    tick();
    io_start(16'hFE06, 1'b0);
    n_chk++; if (o_MDR !== 16'h0000) begin n_fail++;
      $display("FAIL dd_ddr_read got %h want 0000", o_MDR); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] r_seq;
    set_mar(16'hFE04); RW = 0; MIO_EN = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      r_seq[i] = o_R;
    end
    MIO_EN = 0; tick();
    n_chk++; if (r_seq !== 4'b0101) begin n_fail++;
      $display("FAIL b2b_r_seq got %b want 0101", r_seq); end
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    set_mdr(16'h1111);
    set_mar(16'h6000);
    RW = 0; MIO_EN = 1; tick();
    while (o_R !== 1'b1 && n < 200) begin
      tick(); n++;
    end
    n_chk++; if (n !== 64) begin n_fail++;
      $display("FAIL to_cycles got %0d want 64", n); end
    n_chk++; if ({o_bus_err, o_mem_req} !== 2'b10) begin n_fail++;
      $display("FAIL to_err got err=%b req=%b want 1/0", o_bus_err, o_mem_req); end
    n_chk++; if (o_MDR !== 16'h1111) begin n_fail++;
      $display("FAIL to_mdr got %h want 1111", o_MDR); end
    MIO_EN = 0; tick();
    set_mar(16'h6002);
    MIO_EN = 1; tick();
    i_mem_ack = 1; i_mem_rdata = 16'hABCD; tick();
    i_mem_ack = 0; i_mem_rdata = 0;
    n_chk++; if ({o_R, o_MDR} !== {1'b1, 16'hABCD}) begin n_fail++;
      $display("FAIL to_recover got R=%b mdr=%h want 1/ABCD", o_R, o_MDR); end
    n_chk++; if (o_bus_err !== 1'b1) begin n_fail++;
      $display("FAIL to_sticky got %b want 1", o_bus_err); end
    MIO_EN = 0; tick();
  endtask

  task automatic test_reset_mid();
    set_mar(16'h7000);
    RW = 0; MIO_EN = 1; tick();
    n_chk++; if (o_mem_req !== 1'b1) begin n_fail++;
      $display("FAIL rst_pre_req got %b want 1", o_mem_req); end
    #2 i_Rst_n = 0;
    #1;
    n_chk++; if ({o_mem_req, o_bus_err} !== 2'b00) begin n_fail++;
      $display("FAIL rst_async got req=%b err=%b want 0/0", o_mem_req, o_bus_err); end
    MIO_EN = 0;
    tick();
    i_Rst_n = 1;
    i_mem_ack = 1; i_mem_rdata = 16'h9999; tick();
    i_mem_ack = 0; i_mem_rdata = 0;
    n_chk++; if ({o_R, o_MDR} !== 17'h0) begin n_fail++;
      $display("FAIL rst_late_ack got R=%b mdr=%h want 0/0000", o_R, o_MDR); end
    tick();
    n_chk++; if (o_R !== 1'b0) begin n_fail++;
      $display("FAIL rst_late_r got %b want 0", o_R); end
  endtask

  initial begin
    test_reset();
    test_mem_read();
    test_mem_write();
    test_keyboard();
    test_display();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
